// File: rtl/allcomp_ctrl_pkg.sv
// allcomp_ctrl_pkg: shared types and constants for the round-robin comparator controller
// Provides the FSM state enum, default sizing constants and the ID width helper.
package allcomp_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 4;

    // Keep at least one ID bit so a single-requester build still has a legal port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/allcomp.sv
// allcomp: unsigned magnitude comparator
// Ports: a, b operands; g = a>b, l = a<b, e = a==b (exactly one is high).
module allcomp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             g,
    output logic             l,
    output logic             e
);

    assign g = a > b;
    assign l = a < b;
    assign e = a == b;

endmodule

// File: rtl/allcomp_rr_pick.sv
// allcomp_rr_pick: combinational round-robin picker
// Ports: req request vector, ptr scan start; win first set req at or above ptr
// (wrapping), any_req high when any request is set.
module allcomp_rr_pick
    import allcomp_ctrl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] win,
    output logic            any_req
);

    logic [NREQ-1:0] rot;
    logic [ID_W:0]   sum;

    // Rotate so bit k of rot is requester (ptr+k) mod NREQ; scanning k downward
    // lets the lowest set k, i.e. the nearest requester from ptr, win last.
    always_comb begin
        rot     = NREQ'({req, req} >> ptr);
        any_req = |req;
        win     = '0;
        sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (ID_W + 1)'(k);
                win = ID_W'((sum >= (ID_W + 1)'(NREQ)) ? sum - (ID_W + 1)'(NREQ) : sum);
            end
        end
    end

endmodule

// File: rtl/allcomp_rr_ctrl.sv
// allcomp_rr_ctrl: round-robin scheduler sharing one allcomp comparator among NREQ requesters
// Ports: req/a_in/b_in requester side (slice i owns [i*WIDTH +: WIDTH]);
// gnt one-hot grant pulse; rsp_valid/rsp_id/rsp_g/rsp_l/rsp_e tagged result pulse;
// busy high outside IDLE. Async active-low reset rst_n.
module allcomp_rr_ctrl
    import allcomp_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_g,
    output logic                  rsp_l,
    output logic                  rsp_e,
    output logic                  busy
);

    state_t            state, nxt;
    logic [ID_W-1:0]   ptr, owner, win;
    logic              any_req;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              g, l, e;
    logic [WIDTH-1:0]  a_arr [NREQ];
    logic [WIDTH-1:0]  b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
        assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
    end

    allcomp_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .any_req (any_req)
    );

    allcomp #(.WIDTH(WIDTH)) u_cmp (
        .a (a_q),
        .b (b_q),
        .g (g),
        .l (l),
        .e (e)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = (state == IDLE) ? (any_req ? CMP : IDLE) :
              (state == CMP)  ? RESP : IDLE;
    end

    // Grant and valid are decoded from state so an async reset drops them at once.
    always_comb begin
        gnt       = (state == CMP) ? NREQ'(1) << owner : '0;
        rsp_valid = state == RESP;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            owner  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rsp_id <= '0;
            rsp_g  <= 1'b0;
            rsp_l  <= 1'b0;
            rsp_e  <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                owner <= win;
                a_q   <= a_arr[win];
                b_q   <= b_arr[win];
            end
            if (state == CMP) begin
                rsp_id                <= owner;
                {rsp_g, rsp_l, rsp_e} <= {g, l, e};
                ptr                   <= (owner == ID_W'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
            // rsp_id deliberately holds; only the flags return to zero.
            if (state == RESP) {rsp_g, rsp_l, rsp_e} <= 3'b000;
        end
    end

endmodule

// File: tb/tb_allcomp_rr_ctrl.sv
// tb_allcomp_rr_ctrl: self-checking bench for allcomp_rr_ctrl (vector table + scoreboard)
module tb_allcomp_rr_ctrl;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] a_in = '0;
    logic [N*W-1:0] b_in = '0;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic           rsp_g, rsp_l, rsp_e;
    logic           busy;

    allcomp_rr_ctrl #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_g     (rsp_g),
        .rsp_l     (rsp_l),
        .rsp_e     (rsp_e),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [2:0]    gle;
    } rsp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2:0]    gle;
    } vec_t;

    rsp_t sbq[$];
    vec_t vt[8];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any response seen there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got id=%0d gle=%b with nothing expected (cycle %0d)",
                             rsp_id, {rsp_g, rsp_l, rsp_e}, cyc);
                end else begin
                    rsp_t x;
                    x = sbq.pop_front();
                    chk("rsp", {27'd0, rsp_id, rsp_g, rsp_l, rsp_e}, {27'd0, x});
                end
            end else begin
                chk("idle_gle", {29'd0, rsp_g, rsp_l, rsp_e}, 32'd0);
            end
        end
    endtask

    task automatic wait_gnt(input string name, input logic [N-1:0] exp, output int lat, output int at);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (gnt == '0 && k < 20);
        lat = k;
        at  = cyc;
        chk(name, {28'd0, gnt}, {28'd0, exp});
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    initial begin
        int lat, at, prev;
        vt[0] = '{2'd2, 4'hA, 4'h3, 3'b100};
        vt[1] = '{2'd1, 4'hF, 4'hF, 3'b001};
        vt[2] = '{2'd0, 4'h0, 4'h0, 3'b001};
        vt[3] = '{2'd3, 4'hF, 4'h0, 3'b100};
        vt[4] = '{2'd3, 4'h7, 4'h8, 3'b010};
        vt[5] = '{2'd0, 4'h8, 4'h7, 3'b100};
        vt[6] = '{2'd2, 4'h5, 4'h5, 3'b001};
        vt[7] = '{2'd1, 4'h0, 4'hF, 3'b010};

        // Reset held with every requester asserting; then full contention.
        req = 4'b1111;
        set_op(0, 4'h9, 4'h2);
        set_op(1, 4'h7, 4'h7);
        set_op(2, 4'h2, 4'h8);
        set_op(3, 4'h3, 4'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt", {28'd0, gnt}, 32'd0);
            chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_out", {27'd0, rsp_id, rsp_g, rsp_l, rsp_e}, 32'd0);
        end
        rst_n = 1'b1;
        sbq.push_back(rsp_t'({2'd0, 3'b100}));
        sbq.push_back(rsp_t'({2'd1, 3'b001}));
        sbq.push_back(rsp_t'({2'd2, 3'b010}));
        sbq.push_back(rsp_t'({2'd3, 3'b100}));
        prev = 0;
        for (int i = 0; i < N; i++) begin
            wait_gnt("cont_gnt", N'(1) << i, lat, at);
            if (i > 0) chk("cont_gap", at - prev, 32'd3);
            prev = at;
            req[i] = 1'b0;
        end
        tick();
        tick();
        chk("cont_drain", sbq.size(), 32'd0);

        // Single-requester vectors; operands scrambled after grant must not matter.
        for (int v = 0; v < 8; v++) begin
            req = N'(1) << vt[v].id;
            set_op(int'(vt[v].id), vt[v].a, vt[v].b);
            sbq.push_back(rsp_t'({vt[v].id, vt[v].gle}));
            wait_gnt("vec_gnt", N'(1) << vt[v].id, lat, at);
            chk("vec_gnt_lat", lat, 32'd1);
            chk("vec_busy_cmp", {31'd0, busy}, 32'd1);
            req  = '0;
            a_in = N*W'($urandom);
            b_in = N*W'($urandom);
            tick();
            chk("vec_valid", {31'd0, rsp_valid}, 32'd1);
            chk("vec_gnt_off", {28'd0, gnt}, 32'd0);
            tick();
            chk("vec_busy_idle", {31'd0, busy}, 32'd0);
            chk("vec_id_hold", {30'd0, rsp_id}, {30'd0, vt[v].id});
        end
        chk("vec_drain", sbq.size(), 32'd0);

        // Last grant went to 1: pointer at 2, so 0011 serves 0 before 1.
        set_op(0, 4'h5, 4'h6);
        set_op(1, 4'hC, 4'h4);
        req = 4'b0011;
        sbq.push_back(rsp_t'({2'd0, 3'b010}));
        sbq.push_back(rsp_t'({2'd1, 3'b100}));
        wait_gnt("rr_first", 4'b0001, lat, at);
        req[0] = 1'b0;
        wait_gnt("rr_second", 4'b0010, lat, at);
        req[1] = 1'b0;
        tick();
        tick();
        chk("rr_drain", sbq.size(), 32'd0);

        // Reset while requester 3 is in CMP: transaction dropped, pointer back to 0.
        set_op(0, 4'h4, 4'h4);
        set_op(3, 4'h1, 4'h2);
        req = 4'b1001;
        wait_gnt("rstcmp_pre", 4'b1000, lat, at);
        rst_n = 1'b0;
        #1;
        chk("rstcmp_gnt", {28'd0, gnt}, 32'd0);
        chk("rstcmp_busy", {31'd0, busy}, 32'd0);
        chk("rstcmp_valid", {31'd0, rsp_valid}, 32'd0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rstcmp_nothing", sbq.size(), 32'd0);
        req = 4'b1001;
        sbq.push_back(rsp_t'({2'd0, 3'b001}));
        sbq.push_back(rsp_t'({2'd3, 3'b010}));
        wait_gnt("rstcmp_ptr0", 4'b0001, lat, at);
        req[0] = 1'b0;
        wait_gnt("rstcmp_next", 4'b1000, lat, at);
        req[3] = 1'b0;
        tick();
        tick();
        chk("final_drain", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/allcomp_rr_ctrl.md
Name: allcomp_rr_ctrl

Overview:
Round-robin scheduler that shares one magnitude comparator (`allcomp`, WIDTH bits) between NREQ requesters.
Each requester presents an operand pair with a request. The controller arbitrates, captures the winning pair, runs the compare and returns the registered {g,l,e} result tagged with the requester ID.
It sits between client blocks and the comparator datapath, so no client needs a private comparator.

Parameters:
WIDTH, 4, operand width in bits (passed to the comparator).
NREQ, 4, number of requesters (2..16).
ID_W, $clog2(NREQ), localparam; width of the requester ID.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  NREQ  per-requester request; held high with stable operands until granted.
a_in  input  NREQ*WIDTH  operand A; requester i owns bits [i*WIDTH +: WIDTH].
b_in  input  NREQ*WIDTH  operand B; same packing as a_in.
gnt  output  NREQ  one-hot grant pulse, one cycle wide.
rsp_valid  output  1  result valid pulse, one cycle wide.
rsp_id  output  ID_W  index of the requester owning the result.
rsp_g  output  1  A > B (unsigned).
rsp_l  output  1  A < B (unsigned).
rsp_e  output  1  A == B.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n = 0: state = IDLE, RR pointer = 0, operand and owner registers = 0.
  - All outputs read 0: gnt, rsp_valid, rsp_id, rsp_g, rsp_l, rsp_e, busy.
- FSM has three states: IDLE, CMP, RESP.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the winner: the first set req bit scanning upward from the pointer, wrapping NREQ-1 -> 0.
  - At that edge: latch owner and its a/b slices, set gnt[owner] = 1, move to CMP.
- CMP (1 cycle):
  - gnt[owner] is high for exactly this cycle.
  - Comparator evaluates the latched operands.
  - At the end of the cycle: register {g,l,e}, set rsp_valid = 1, rsp_id = owner, pointer = (owner+1) mod NREQ, move to RESP.
- RESP (1 cycle):
  - rsp_valid high with the registered result.
  - At the end of the cycle: clear rsp_valid, rsp_g, rsp_l, rsp_e (rsp_id holds its value) and return to IDLE.
- Latency and throughput:
  - Request sampled at edge T. gnt is high in cycle T+1, rsp_valid in cycle T+2.
  - The next arbitration happens at the edge ending the IDLE cycle T+3, so peak throughput is one compare per 3 cycles.
- Requester rule: deassert req (or present a new pair) no later than the edge ending the gnt cycle. A req still high when IDLE is next sampled is treated as a new request.
- Operands are sampled only at the arbitration edge; later changes on a_in/b_in do not affect the in-flight result.
- Result encoding:
  - Unsigned compare.
  - When rsp_valid = 1, exactly one of g/l/e is 1.
  - When rsp_valid = 0, all three are 0.
- Pointer wrap: after a grant to NREQ-1 the pointer goes to 0.
- Simultaneous requests: only one grant per arbitration. Losers keep req high and are served in round-robin order. No requester waits more than NREQ grants.
- Reset mid-operation (CMP or RESP): the transaction is discarded and no rsp_valid is issued afterwards. The requester must re-request.
- A req arriving while busy is simply held by the requester; the controller does not queue it internally.

Decomposition:
- Package allcomp_ctrl_pkg holds:
  - state enum {IDLE, CMP, RESP}, 2 bits;
  - default WIDTH and NREQ constants;
  - a function computing ID_W.
- One natural sub-module: allcomp_rr_pick.
  - Purely combinational round-robin picker.
  - Inputs: req, pointer. Outputs: winner ID, any_req.
- The existing allcomp comparator is instantiated once with width = WIDTH on the latched operands.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with req = 4'b1111 -> gnt = 0, rsp_valid = 0, busy = 0; first grant after release is gnt = 4'b0001.
- Single request: req[2] = 1, a slice = 4'b1010, b slice = 4'b0011 -> gnt = 4'b0100 one cycle later; rsp_valid = 1, rsp_id = 2, {g,l,e} = 100 the cycle after.
- Equality and less-than: requester 1 with a = 4'hF, b = 4'hF -> {g,l,e} = 001; then a = 4'h0, b = 4'hF -> 010.
- Full contention after reset: req = 4'b1111 held until each grant -> grants in order 0, 1, 2, 3, each 3 cycles apart; rsp_id follows the same order.
- Round-robin fairness: after a grant to 1, assert req = 4'b0011 -> grant 0 first (scan 2, 3, 0), then 1.
- Reset during CMP: assert rst_n = 0 while gnt[3] = 1 -> gnt drops immediately; no rsp_valid after release; the pointer restarts at 0.
